multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL provide port `clk`, input, 1 bit: single clock, rising-edge.
REQ-002 The block SHALL provide port `reset`, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL provide port `op`, input, 7 bits: opcode from the latched instruction register.
REQ-004 The block SHALL provide inputs `funct3` (3 bits) and `funct7b5` (1 bit): instruction fields.
REQ-005 The block SHALL provide inputs `Zero`, `LessThan` and `LessThanUnsigned`, 1 bit each: ALU flags.
REQ-006 The block SHALL provide port `MemReady`, input, 1 bit: the memory access completes in the cycle it is high.
REQ-007 The block SHALL provide outputs `PCWrite`, `AdrSrc`, `MemWrite`, `IRWrite` and `RegWrite`, 1 bit each.
REQ-008 The block SHALL provide outputs `ResultSrc`, `ALUSrcA` and `ALUSrcB`, 2 bits each.
REQ-009 The block SHALL provide outputs `ImmSrc` (3 bits), `ALUControl` (4 bits) and `Illegal` (1 bit).

Function
REQ-010 The state machine SHALL have these states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, JLINK, UTYPE, ERROR.
REQ-011 Output encodings SHALL be:
- AdrSrc: 0 = PC, 1 = Result.
- ALUSrcA: 00 = PC, 01 = OldPC, 10 = RD1, 11 = zero.
- ALUSrcB: 00 = RD2, 01 = ImmExt, 10 = constant 4.
- ResultSrc: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- ImmSrc: 000 = I, 001 = S, 010 = B, 011 = J, 100 = U, decoded combinationally from `op`.
REQ-012 FETCH SHALL behave as follows:
- Outputs: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10.
- While MemReady=0: hold state, IRWrite=0, PCWrite=0.
- When MemReady=1: IRWrite=1 and PCWrite=1 in that same cycle, next state DECODE.
REQ-013 DECODE SHALL drive ALUSrcA=01, ALUSrcB=01, add (branch/JAL target into ALUOut), then dispatch on `op`:
- lw or sw -> MEMADR.
- R-type -> EXECR.
- I-ALU -> EXECI.
- branch -> BRANCH.
- jal -> JAL.
- jalr -> JALR.
- lui or auipc -> UTYPE.
- any other opcode -> ERROR (macro on) or FETCH (macro off).
REQ-014 MEMADR SHALL compute RD1+Imm and go to MEMREAD (lw) or MEMWRITE (sw).
REQ-015 MEMREAD SHALL drive AdrSrc=1, ResultSrc=00, hold until MemReady=1, then go to MEMWB.
REQ-016 MEMWB SHALL drive ResultSrc=01, RegWrite=1, then go to FETCH.
REQ-017 MEMWRITE SHALL drive AdrSrc=1 and MemWrite=1 every cycle until MemReady=1, then go to FETCH.
REQ-018 EXECR SHALL use RD1 op RD2 with the funct decode; EXECI SHALL use RD1 op Imm; both SHALL then go to ALUWB.
REQ-019 ALUWB SHALL drive ResultSrc=00, RegWrite=1, then go to FETCH.
REQ-020 BRANCH SHALL:
- compare RD1 with RD2 (ALUOp=01);
- drive ResultSrc=00 and PCWrite = branch condition evaluated from funct3 and the flags in the same cycle (Mealy);
- go to FETCH.
REQ-021 JAL SHALL:
- drive ResultSrc=00 and PCWrite=1;
- compute OldPC+4 into ALUOut;
- go to ALUWB.
REQ-022 JALR SHALL:
- compute RD1+Imm;
- drive ResultSrc=10 and PCWrite=1;
- go to JLINK.
REQ-023 JLINK SHALL drive OldPC+4 with ResultSrc=10 and RegWrite=1, then go to FETCH.
REQ-024 UTYPE SHALL compute ALUSrcA=11 (lui) or 01 (auipc) with ALUSrcB=01 and add, then go to ALUWB.
REQ-025 ALUControl SHALL be add for ALUOp=00, sub for ALUOp=01, and the funct3/funct7b5 decode for ALUOp=10; funct7b5 selects sub only when op[5]=1.
REQ-026 Zero-wait cycle counts SHALL be:

| Instruction | Cycles |
|---|---|
| lw | 5 |
| sw, R, I, jal, jalr, lui, auipc | 4 |
| branch | 3 |

Each wait cycle SHALL add exactly one cycle.
REQ-027 All outputs except PCWrite and IRWrite SHALL be Moore, decoded from the state register only.

Reset
REQ-028 When `reset`=1 at a rising edge, the next state SHALL be FETCH and `Illegal` SHALL be 0.
REQ-029 During the reset cycle and the first FETCH cycle, MemWrite, RegWrite and PCWrite SHALL be 0.
REQ-030 A reset arriving mid-instruction, including during a MEMWRITE wait, SHALL abort the instruction with no further write strobes after the edge.

Configuration
REQ-031 The macro `MC_ILLEGAL_TRAP_EN` SHALL control illegal-opcode handling:
- Defined: an unknown opcode in DECODE enters ERROR. ERROR holds, asserts Illegal=1 and suppresses all write strobes until reset.
- Undefined: the ERROR state is absent, Illegal is tied 0, and an unknown opcode returns to FETCH with no writes (NOP).

Structure
REQ-032 The shared package `mc_pkg` SHALL hold the state enum, opcode constants, ALUOp encodings and the mux-select encodings.
REQ-033 The block SHALL instantiate the existing `aludec` and `branchdec` blocks unchanged.
REQ-034 One new combinational sub-module, `mc_outdec`, SHALL hold the state-to-control output table.

Verification
REQ-035 The bench SHALL apply `add` (op=0110011) with MemReady=1 and check the state sequence FETCH, DECODE, EXECR, ALUWB, FETCH and exactly one RegWrite pulse.
REQ-036 The bench SHALL apply `lw` with MemReady low for 3 cycles in MEMREAD and check completion in 8 cycles, with RegWrite in MEMWB only.
REQ-037 The bench SHALL apply `beq` with Zero=1, then with Zero=0, and check PCWrite=1, then PCWrite=0, in BRANCH, each in 3 cycles.
REQ-038 The bench SHALL apply `jalr` and check PCWrite in JALR, then RegWrite with ResultSrc=10 in JLINK.
REQ-039 The bench SHALL assert reset during a MEMWRITE wait and check MemWrite=0 and state FETCH after the edge.
REQ-040 The bench SHALL apply op=0000000 and check Illegal=1 sticky with no strobes (macro on), or a return to FETCH in 2 cycles (macro off).

Source files
------------

// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle RISC-V controller: state encoding,
// opcodes, ALUOp codes, datapath mux selects and the Moore control bundle.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_JLINK    = 4'd12,
    S_UTYPE    = 4'd13
`ifdef MC_ILLEGAL_TRAP_EN
    , S_ERROR  = 4'd14
`endif
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic       ADR_PC     = 1'b0;
  localparam logic       ADR_RESULT = 1'b1;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  typedef struct packed {
    logic       adrsrc;
    logic       memwrite;
    logic       regwrite;
    logic [1:0] resultsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{
    adrsrc:    ADR_PC,
    memwrite:  1'b0,
    regwrite:  1'b0,
    resultsrc: RES_ALUOUT,
    alusrca:   SRCA_PC,
    alusrcb:   SRCB_RD2,
    aluop:     ALUOP_ADD
  };

  function automatic logic [2:0] imm_src(input logic [6:0] op);
    logic [2:0] sel;
    case (op)
      OP_STORE:          sel = IMM_S;
      OP_BRANCH:         sel = IMM_B;
      OP_JAL:            sel = IMM_J;
      OP_LUI, OP_AUIPC:  sel = IMM_U;
      default:           sel = IMM_I;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/aludec.sv
// ALU decoder: maps ALUOp plus funct3/funct7b5 to the 4-bit ALU operation.
module aludec
  import mc_pkg::*;
(
  input  logic       opb5,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic [1:0] ALUOp,
  output logic [3:0] ALUControl
);

  // funct7b5 only distinguishes sub from add for register-register ops
  always_comb begin
    ALUControl = ALU_ADD;
    case (ALUOp)
      ALUOP_ADD: ALUControl = ALU_ADD;
      ALUOP_SUB: ALUControl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000: begin
            if (opb5 && funct7b5) ALUControl = ALU_SUB;
            else                  ALUControl = ALU_ADD;
          end
          3'b001: ALUControl = ALU_SLL;
          3'b010: ALUControl = ALU_SLT;
          3'b011: ALUControl = ALU_SLTU;
          3'b100: ALUControl = ALU_XOR;
          3'b101: begin
            if (funct7b5) ALUControl = ALU_SRA;
            else          ALUControl = ALU_SRL;
          end
          3'b110: ALUControl = ALU_OR;
          3'b111: ALUControl = ALU_AND;
          default: ALUControl = ALU_ADD;
        endcase
      end
      default: ALUControl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/branchdec.sv
// Branch condition decoder: evaluates the RV32I branch predicate from ALU flags.
module branchdec (
  input  logic [2:0] funct3,
  input  logic       Zero,
  input  logic       LessThan,
  input  logic       LessThanUnsigned,
  output logic       taken
);

  // beq/bne/blt/bge/bltu/bgeu; reserved funct3 codes never branch
  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = Zero;
      3'b001:  taken = ~Zero;
      3'b100:  taken = LessThan;
      3'b101:  taken = ~LessThan;
      3'b110:  taken = LessThanUnsigned;
      3'b111:  taken = ~LessThanUnsigned;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_outdec.sv
// State-to-control table for the Moore outputs of the multicycle controller.
module mc_outdec
  import mc_pkg::*;
(
  input  state_t state,
  input  logic   is_lui,
  output ctrl_t  ctrl
);

  // one row per state; anything unlisted (including ERROR) is idle with no strobes
  always_comb begin
    ctrl = CTRL_IDLE;
    case (state)
      S_FETCH: begin
        ctrl.adrsrc    = ADR_PC;
        ctrl.alusrca   = SRCA_PC;
        ctrl.alusrcb   = SRCB_FOUR;
        ctrl.resultsrc = RES_ALURESULT;
      end
      S_DECODE: begin
        ctrl.alusrca = SRCA_OLDPC;
        ctrl.alusrcb = SRCB_IMM;
      end
      S_MEMADR: begin
        ctrl.alusrca = SRCA_RD1;
        ctrl.alusrcb = SRCB_IMM;
      end
      S_MEMREAD: begin
        ctrl.adrsrc    = ADR_RESULT;
        ctrl.resultsrc = RES_ALUOUT;
      end
      S_MEMWB: begin
        ctrl.resultsrc = RES_DATA;
        ctrl.regwrite  = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl.adrsrc    = ADR_RESULT;
        ctrl.resultsrc = RES_ALUOUT;
        ctrl.memwrite  = 1'b1;
      end
      S_EXECR: begin
        ctrl.alusrca = SRCA_RD1;
        ctrl.alusrcb = SRCB_RD2;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ctrl.alusrca = SRCA_RD1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.resultsrc = RES_ALUOUT;
        ctrl.regwrite  = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alusrca   = SRCA_RD1;
        ctrl.alusrcb   = SRCB_RD2;
        ctrl.aluop     = ALUOP_SUB;
        ctrl.resultsrc = RES_ALUOUT;
      end
      S_JAL: begin
        ctrl.alusrca   = SRCA_OLDPC;
        ctrl.alusrcb   = SRCB_FOUR;
        ctrl.resultsrc = RES_ALUOUT;
      end
      S_JALR: begin
        ctrl.alusrca   = SRCA_RD1;
        ctrl.alusrcb   = SRCB_IMM;
        ctrl.resultsrc = RES_ALURESULT;
      end
      S_JLINK: begin
        ctrl.alusrca   = SRCA_OLDPC;
        ctrl.alusrcb   = SRCB_FOUR;
        ctrl.resultsrc = RES_ALURESULT;
        ctrl.regwrite  = 1'b1;
      end
      S_UTYPE: begin
        if (is_lui) ctrl.alusrca = SRCA_ZERO;
        else        ctrl.alusrca = SRCA_OLDPC;
        ctrl.alusrcb = SRCB_IMM;
      end
      default: ctrl = CTRL_IDLE;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control unit. Define MC_ILLEGAL_TRAP_EN to trap unknown
// opcodes in a sticky ERROR state; otherwise they retire as NOPs.
module multicycle_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       LessThan,
  input  logic       LessThanUnsigned,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSrc,
  output logic [3:0] ALUControl,
  output logic       Illegal
);

  state_t state_r;
  state_t next_state_s;
  logic   armed_r;
  logic   fetch_go_s;
  logic   taken_s;
  logic   pcwrite_s;
  logic   irwrite_s;
  ctrl_t  ctrl_s;

  // state register; armed_r keeps the first FETCH after reset strobe-free
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_FETCH;
      armed_r <= 1'b0;
    end else begin
      state_r <= next_state_s;
      armed_r <= 1'b1;
    end
  end

  assign fetch_go_s = MemReady & armed_r;

  // next-state logic
  always_comb begin
    next_state_s = S_FETCH;
    case (state_r)
      S_FETCH: begin
        if (fetch_go_s) next_state_s = S_DECODE;
        else            next_state_s = S_FETCH;
      end
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: next_state_s = S_MEMADR;
          OP_RTYPE:          next_state_s = S_EXECR;
          OP_ITYPE:          next_state_s = S_EXECI;
          OP_BRANCH:         next_state_s = S_BRANCH;
          OP_JAL:            next_state_s = S_JAL;
          OP_JALR:           next_state_s = S_JALR;
          OP_LUI, OP_AUIPC:  next_state_s = S_UTYPE;
`ifdef MC_ILLEGAL_TRAP_EN
          default:           next_state_s = S_ERROR;
`else
          default:           next_state_s = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        if (op == OP_STORE) next_state_s = S_MEMWRITE;
        else                next_state_s = S_MEMREAD;
      end
      S_MEMREAD: begin
        if (MemReady) next_state_s = S_MEMWB;
        else          next_state_s = S_MEMREAD;
      end
      S_MEMWB:    next_state_s = S_FETCH;
      S_MEMWRITE: begin
        if (MemReady) next_state_s = S_FETCH;
        else          next_state_s = S_MEMWRITE;
      end
      S_EXECR:  next_state_s = S_ALUWB;
      S_EXECI:  next_state_s = S_ALUWB;
      S_ALUWB:  next_state_s = S_FETCH;
      S_BRANCH: next_state_s = S_FETCH;
      S_JAL:    next_state_s = S_ALUWB;
      S_JALR:   next_state_s = S_JLINK;
      S_JLINK:  next_state_s = S_FETCH;
      S_UTYPE:  next_state_s = S_ALUWB;
`ifdef MC_ILLEGAL_TRAP_EN
      S_ERROR:  next_state_s = S_ERROR;
`endif
      default:  next_state_s = S_FETCH;
    endcase
  end

  // Mealy strobes: PC and IR updates depend on MemReady and the branch outcome
  always_comb begin
    pcwrite_s = 1'b0;
    irwrite_s = 1'b0;
    case (state_r)
      S_FETCH: begin
        pcwrite_s = fetch_go_s;
        irwrite_s = fetch_go_s;
      end
      S_BRANCH:       pcwrite_s = taken_s;
      S_JAL, S_JALR:  pcwrite_s = 1'b1;
      default:        pcwrite_s = 1'b0;
    endcase
  end

  mc_outdec u_outdec (
    .state  (state_r),
    .is_lui (op == OP_LUI),
    .ctrl   (ctrl_s)
  );

  aludec u_aludec (
    .opb5       (op[5]),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .ALUOp      (ctrl_s.aluop),
    .ALUControl (ALUControl)
  );

  branchdec u_branchdec (
    .funct3           (funct3),
    .Zero             (Zero),
    .LessThan         (LessThan),
    .LessThanUnsigned (LessThanUnsigned),
    .taken            (taken_s)
  );

  // reset overrides every architectural write, even mid-instruction
  assign PCWrite   = pcwrite_s & ~reset;
  assign IRWrite   = irwrite_s & ~reset;
  assign MemWrite  = ctrl_s.memwrite & ~reset;
  assign RegWrite  = ctrl_s.regwrite & ~reset;
  assign AdrSrc    = ctrl_s.adrsrc;
  assign ResultSrc = ctrl_s.resultsrc;
  assign ALUSrcA   = ctrl_s.alusrca;
  assign ALUSrcB   = ctrl_s.alusrcb;
  assign ImmSrc    = imm_src(op);

`ifdef MC_ILLEGAL_TRAP_EN
  assign Illegal = (state_r == S_ERROR);
`else
  assign Illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: instruction sequences, wait states,
// mid-instruction reset and illegal-opcode handling.
module tb_multicycle_controller;
  import mc_pkg::*;

  logic       clk;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       LessThan;
  logic       LessThanUnsigned;
  logic       MemReady;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ImmSrc;
  logic [3:0] ALUControl;
  logic       Illegal;

  int vectors;
  int miscompares;
  int cyc;
  int pcw_cnt;
  int irw_cnt;
  int regw_cnt;
  int memw_cnt;

  multicycle_controller dut (
    .clk              (clk),
    .reset            (reset),
    .op               (op),
    .funct3           (funct3),
    .funct7b5         (funct7b5),
    .Zero             (Zero),
    .LessThan         (LessThan),
    .LessThanUnsigned (LessThanUnsigned),
    .MemReady         (MemReady),
    .PCWrite          (PCWrite),
    .AdrSrc           (AdrSrc),
    .MemWrite         (MemWrite),
    .IRWrite          (IRWrite),
    .RegWrite         (RegWrite),
    .ResultSrc        (ResultSrc),
    .ALUSrcA          (ALUSrcA),
    .ALUSrcB          (ALUSrcB),
    .ImmSrc           (ImmSrc),
    .ALUControl       (ALUControl),
    .Illegal          (Illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors = vectors + 1;
    assert (obs === exp)
    else begin
      miscompares = miscompares + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    cyc = 0; pcw_cnt = 0; irw_cnt = 0; regw_cnt = 0; memw_cnt = 0;
  endtask

  // check the current state and tally this cycle's strobes
  task automatic at(input state_t exp, input string tag);
    #1;
    chk({tag, ".state"}, 32'(dut.state_r), 32'(exp));
    cyc      = cyc + 1;
    pcw_cnt  = pcw_cnt + int'(PCWrite);
    irw_cnt  = irw_cnt + int'(IRWrite);
    regw_cnt = regw_cnt + int'(RegWrite);
    memw_cnt = memw_cnt + int'(MemWrite);
  endtask

  task automatic done(input string tag, input int n);
    #1;
    chk({tag, ".back_to_fetch"}, 32'(dut.state_r), 32'(S_FETCH));
    chk({tag, ".cycles"}, 32'(cyc), 32'(n));
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    clr();
    reset = 1'b1; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0;
    Zero = 1'b0; LessThan = 1'b0; LessThanUnsigned = 1'b0; MemReady = 1'b1;

    // reset cycle: FETCH, no strobes, Illegal low
    nxt(); nxt(); #1;
    chk("rst.state", 32'(dut.state_r), 32'(S_FETCH));
    chk("rst.pcwrite", 32'(PCWrite), 32'd0);
    chk("rst.irwrite", 32'(IRWrite), 32'd0);
    chk("rst.memwrite", 32'(MemWrite), 32'd0);
    chk("rst.regwrite", 32'(RegWrite), 32'd0);
    chk("rst.illegal", 32'(Illegal), 32'd0);
    reset = 1'b0; #1;
    chk("first_fetch.pcwrite", 32'(PCWrite), 32'd0);
    chk("first_fetch.irwrite", 32'(IRWrite), 32'd0);
    nxt();

    // add x,y,z
    op = OP_RTYPE; funct3 = 3'b000; funct7b5 = 1'b0; clr();
    at(S_FETCH, "add"); chk("add.fetch.pcwrite", 32'(PCWrite), 32'd1);
    chk("add.fetch.irwrite", 32'(IRWrite), 32'd1); nxt();
    at(S_DECODE, "add"); chk("add.dec.srca", 32'(ALUSrcA), 32'd1); nxt();
    at(S_EXECR, "add"); chk("add.aluctl", 32'(ALUControl), 32'(ALU_ADD)); nxt();
    at(S_ALUWB, "add"); chk("add.wb.ressrc", 32'(ResultSrc), 32'd0); nxt();
    done("add", 4);
    chk("add.regw_pulses", 32'(regw_cnt), 32'd1);
    chk("add.memw_pulses", 32'(memw_cnt), 32'd0);

    // addi with funct7b5=1 must still add (op[5]=0)
    op = OP_ITYPE; funct3 = 3'b000; funct7b5 = 1'b1; clr();
    at(S_FETCH, "addi"); nxt();
    at(S_DECODE, "addi"); nxt();
    at(S_EXECI, "addi"); chk("addi.aluctl", 32'(ALUControl), 32'(ALU_ADD));
    chk("addi.srcb", 32'(ALUSrcB), 32'd1); nxt();
    at(S_ALUWB, "addi"); nxt();
    done("addi", 4);

    // lw with three MEMREAD wait cycles
    op = OP_LOAD; funct7b5 = 1'b0; funct3 = 3'b010; clr();
    at(S_FETCH, "lw"); nxt();
    at(S_DECODE, "lw"); nxt();
    at(S_MEMADR, "lw"); chk("lw.memadr.srca", 32'(ALUSrcA), 32'd2); nxt();
    MemReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      at(S_MEMREAD, "lw.wait"); chk("lw.wait.regwrite", 32'(RegWrite), 32'd0);
      chk("lw.wait.adrsrc", 32'(AdrSrc), 32'd1); nxt();
    end
    MemReady = 1'b1;
    at(S_MEMREAD, "lw.rd"); nxt();
    at(S_MEMWB, "lw"); chk("lw.wb.regwrite", 32'(RegWrite), 32'd1);
    chk("lw.wb.ressrc", 32'(ResultSrc), 32'd1); nxt();
    done("lw", 8);
    chk("lw.regw_pulses", 32'(regw_cnt), 32'd1);

    // beq taken
    op = OP_BRANCH; funct3 = 3'b000; Zero = 1'b1; clr();
    at(S_FETCH, "beq_t"); nxt();
    at(S_DECODE, "beq_t"); chk("beq.immsrc", 32'(ImmSrc), 32'd2); nxt();
    at(S_BRANCH, "beq_t"); chk("beq_t.pcwrite", 32'(PCWrite), 32'd1);
    chk("beq_t.aluctl", 32'(ALUControl), 32'(ALU_SUB)); nxt();
    done("beq_t", 3);

    // beq not taken
    Zero = 1'b0; clr();
    at(S_FETCH, "beq_n"); nxt();
    at(S_DECODE, "beq_n"); nxt();
    at(S_BRANCH, "beq_n"); chk("beq_n.pcwrite", 32'(PCWrite), 32'd0); nxt();
    done("beq_n", 3);
    chk("beq_n.pcw_pulses", 32'(pcw_cnt), 32'd1);

    // jalr
    op = OP_JALR; clr();
    at(S_FETCH, "jalr"); nxt();
    at(S_DECODE, "jalr"); nxt();
    at(S_JALR, "jalr"); chk("jalr.pcwrite", 32'(PCWrite), 32'd1);
    chk("jalr.regwrite", 32'(RegWrite), 32'd0); nxt();
    at(S_JLINK, "jalr"); chk("jlink.regwrite", 32'(RegWrite), 32'd1);
    chk("jlink.ressrc", 32'(ResultSrc), 32'd2);
    chk("jlink.pcwrite", 32'(PCWrite), 32'd0); nxt();
    done("jalr", 4);

    // jal
    op = OP_JAL; clr();
    at(S_FETCH, "jal"); nxt();
    at(S_DECODE, "jal"); chk("jal.immsrc", 32'(ImmSrc), 32'd3); nxt();
    at(S_JAL, "jal"); chk("jal.pcwrite", 32'(PCWrite), 32'd1);
    chk("jal.ressrc", 32'(ResultSrc), 32'd0);
    chk("jal.srcb", 32'(ALUSrcB), 32'd2); nxt();
    at(S_ALUWB, "jal"); chk("jal.wb.regwrite", 32'(RegWrite), 32'd1); nxt();
    done("jal", 4);

    // lui
    op = OP_LUI; clr();
    at(S_FETCH, "lui"); nxt();
    at(S_DECODE, "lui"); nxt();
    at(S_UTYPE, "lui"); chk("lui.srca", 32'(ALUSrcA), 32'd3);
    chk("lui.immsrc", 32'(ImmSrc), 32'd4); nxt();
    at(S_ALUWB, "lui"); nxt();
    done("lui", 4);

    // sw stalled in MEMWRITE, then reset mid-wait
    op = OP_STORE; clr();
    at(S_FETCH, "sw"); nxt();
    at(S_DECODE, "sw"); chk("sw.immsrc", 32'(ImmSrc), 32'd1); nxt();
    at(S_MEMADR, "sw"); nxt();
    MemReady = 1'b0;
    at(S_MEMWRITE, "sw.wait"); chk("sw.wait.memwrite", 32'(MemWrite), 32'd1);
    chk("sw.wait.adrsrc", 32'(AdrSrc), 32'd1); nxt();
    at(S_MEMWRITE, "sw.wait2"); chk("sw.wait2.memwrite", 32'(MemWrite), 32'd1);
    reset = 1'b1; #1;
    chk("sw.rstcyc.memwrite", 32'(MemWrite), 32'd0);
    nxt(); #1;
    chk("sw.rst.state", 32'(dut.state_r), 32'(S_FETCH));
    chk("sw.rst.memwrite", 32'(MemWrite), 32'd0);
    chk("sw.rst.pcwrite", 32'(PCWrite), 32'd0);
    reset = 1'b0; MemReady = 1'b1; #1;
    chk("sw.first_fetch.pcwrite", 32'(PCWrite), 32'd0);
    nxt();

    // unknown opcode
    op = 7'b0000000; clr();
    at(S_FETCH, "ill"); nxt();
    at(S_DECODE, "ill"); nxt();
`ifdef MC_ILLEGAL_TRAP_EN
    clr();
    for (int i = 0; i < 4; i++) begin
      at(S_ERROR, "ill.err"); chk("ill.illegal", 32'(Illegal), 32'd1); nxt();
    end
    chk("ill.pcw_pulses", 32'(pcw_cnt), 32'd0);
    chk("ill.irw_pulses", 32'(irw_cnt), 32'd0);
    chk("ill.regw_pulses", 32'(regw_cnt), 32'd0);
    chk("ill.memw_pulses", 32'(memw_cnt), 32'd0);
    reset = 1'b1; nxt(); #1;
    chk("ill.rst.illegal", 32'(Illegal), 32'd0);
    chk("ill.rst.state", 32'(dut.state_r), 32'(S_FETCH));
    reset = 1'b0;
`else
    done("ill", 2);
    chk("ill.regw_pulses", 32'(regw_cnt), 32'd0);
    chk("ill.memw_pulses", 32'(memw_cnt), 32'd0);
    chk("ill.illegal", 32'(Illegal), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
